// File: rtl/apb_timer_scratch_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge and its timer/scratch slaves.
interface apb_timer_scratch_slave_if;
   logic [2:0]  pselx;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;

   modport master (output pselx, penable, pwrite, paddr, pwdata, input prdata);
   modport slave  (input pselx, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/apb_timer_scratch_slave.sv
// APB slave with a 32-bit down-counting timer, eight scratch registers and
// a phase-tracking FSM that records protocol violations in STATUS.proterr.
module apb_timer_scratch_slave #(
   parameter int unsigned SLV_ID   = 0,
   parameter logic [31:0] RST_LOAD = 32'h0000_0000
) (
   input  logic                            hclk,
   input  logic                            hresetn,
   apb_timer_scratch_slave_if.slave        apb,
   output logic                            irq,
   output logic                            perr
);
   localparam logic [1:0] SEL_IDX = SLV_ID[1:0];

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state, state_nxt;

   logic        sel;
   logic        match;
   logic [31:0] lat_addr;
   logic        lat_write;
   logic        do_latch, do_commit, do_perr;

   logic [2:0]  ctrl;
   logic [31:0] load, count;
   logic        timeout, proterr;
   logic [31:0] scr [8];
   logic [31:0] prdata_q;

   logic [5:0]  idx;
   logic [5:0]  scr_off;
   logic [2:0]  scr_idx;
   logic        is_scr;
   logic [31:0] rd_data;
   logic        wr_ctrl, wr_load, wr_status, wr_scr;
   logic        expire;
   logic        unused_bits;

   assign sel     = apb.pselx[SEL_IDX];
   assign match   = (apb.paddr == lat_addr) && (apb.pwrite == lat_write);
   assign idx     = apb.paddr[7:2];
   assign scr_off = idx - 6'd4;
   assign scr_idx = scr_off[2:0];
   assign is_scr  = (idx >= 6'd4) && (idx <= 6'd11);
   assign unused_bits = ^{apb.pselx, scr_off[5:3]};

   always_ff @(posedge hclk) begin
      if (!hresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (sel && !apb.penable) state_nxt = SETUP;
         SETUP: begin
            if (!sel)             state_nxt = IDLE;
            else if (apb.penable) state_nxt = match ? ACCESS : IDLE;
         end
         ACCESS: begin
            if (sel && !apb.penable) state_nxt = SETUP;
            else                     state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      do_latch  = 1'b0;
      do_commit = 1'b0;
      do_perr   = 1'b0;
      unique case (state)
         IDLE: begin
            do_latch = sel && !apb.penable;
            do_perr  = sel && apb.penable;
         end
         SETUP: begin
            if (!sel) begin
               do_perr = 1'b1;
            end else if (!apb.penable) begin
               do_latch = 1'b1;
               do_perr  = 1'b1;
            end else if (match) begin
               do_commit = lat_write;
            end else begin
               do_perr = 1'b1;
            end
         end
         ACCESS: begin
            do_latch = sel && !apb.penable;
            do_perr  = sel && apb.penable;
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_data = '0;
      case (idx)
         6'd0:    rd_data = {29'b0, ctrl};
         6'd1:    rd_data = load;
         6'd2:    rd_data = count;
         6'd3:    rd_data = {30'b0, proterr, timeout};
         default: if (is_scr) rd_data = scr[scr_idx];
      endcase
   end

   assign wr_ctrl   = do_commit && (idx == 6'd0);
   assign wr_load   = do_commit && (idx == 6'd1);
   assign wr_status = do_commit && (idx == 6'd3);
   assign wr_scr    = do_commit && is_scr;
   assign expire    = ctrl[0] && (count == '0);

   // Read data is captured at setup, so COUNT is a snapshot of that edge.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         lat_addr  <= '0;
         lat_write <= 1'b0;
         prdata_q  <= '0;
      end else if (do_latch) begin
         lat_addr  <= apb.paddr;
         lat_write <= apb.pwrite;
         prdata_q  <= apb.pwrite ? '0 : rd_data;
      end else if (state_nxt == IDLE) begin
         prdata_q  <= '0;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         ctrl    <= '0;
         load    <= RST_LOAD;
         count   <= RST_LOAD;
         timeout <= 1'b0;
         proterr <= 1'b0;
         irq     <= 1'b0;
         perr    <= 1'b0;
      end else begin
         if (wr_load) begin
            load  <= apb.pwdata;
            count <= apb.pwdata;
         end else if (ctrl[0]) begin
            if (count != '0) count <= count - 32'd1;
            else if (ctrl[2]) count <= load;
         end
         if (wr_ctrl)                  ctrl    <= apb.pwdata[2:0];
         else if (expire && !ctrl[2])  ctrl[0] <= 1'b0;
         // Hardware sets win over a same-cycle write-1-to-clear.
         timeout <= expire  | (timeout & ~(wr_status & apb.pwdata[0]));
         proterr <= do_perr | (proterr & ~(wr_status & apb.pwdata[1]));
         irq     <= timeout & ctrl[1];
         perr    <= proterr;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         for (int i = 0; i < 8; i++) scr[i] <= '0;
      end else if (wr_scr) begin
         scr[scr_idx] <= apb.pwdata;
      end
   end

   assign apb.prdata = prdata_q;
endmodule

// File: tb/tb_apb_timer_scratch_slave.sv
// Directed bench for apb_timer_scratch_slave: register map table, timer,
// protocol-error, back-to-back and mid-transfer reset sequences.
module tb_apb_timer_scratch_slave;
   localparam logic [31:0] RST0 = 32'h0000_00C8;
   localparam int NV = 18;

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      string       name;
   } vec_t;

   logic       hclk = 1'b0;
   logic       hresetn;
   logic [2:0] irq, perr;
   int         checks = 0;
   int         failures = 0;
   vec_t       tbl [NV];

   always #5 hclk = ~hclk;

   apb_timer_scratch_slave_if bus0 ();
   apb_timer_scratch_slave_if bus1 ();
   apb_timer_scratch_slave_if bus2 ();

   assign bus1.pselx   = bus0.pselx;
   assign bus1.penable = bus0.penable;
   assign bus1.pwrite  = bus0.pwrite;
   assign bus1.paddr   = bus0.paddr;
   assign bus1.pwdata  = bus0.pwdata;
   assign bus2.pselx   = bus0.pselx;
   assign bus2.penable = bus0.penable;
   assign bus2.pwrite  = bus0.pwrite;
   assign bus2.paddr   = bus0.paddr;
   assign bus2.pwdata  = bus0.pwdata;

   apb_timer_scratch_slave #(.SLV_ID(0), .RST_LOAD(RST0)) dut0 (
      .hclk(hclk), .hresetn(hresetn), .apb(bus0.slave), .irq(irq[0]), .perr(perr[0]));
   apb_timer_scratch_slave #(.SLV_ID(1)) dut1 (
      .hclk(hclk), .hresetn(hresetn), .apb(bus1.slave), .irq(irq[1]), .perr(perr[1]));
   apb_timer_scratch_slave #(.SLV_ID(2)) dut2 (
      .hclk(hclk), .hresetn(hresetn), .apb(bus2.slave), .irq(irq[2]), .perr(perr[2]));

   function automatic logic [31:0] pget(input int sid);
      case (sid)
         1:       return bus1.prdata;
         2:       return bus2.prdata;
         default: return bus0.prdata;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input logic [2:0] sel, input logic en, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
      bus0.pselx   = sel;
      bus0.penable = en;
      bus0.pwrite  = wr;
      bus0.paddr   = addr;
      bus0.pwdata  = data;
   endtask

   task automatic idle();
      drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic apb_write(input int sid, input logic [31:0] addr, input logic [31:0] data);
      drive(3'(1 << sid), 1'b0, 1'b1, addr, data);
      tick();
      bus0.penable = 1'b1;
      tick();
      idle();
   endtask

   task automatic apb_read(input int sid, input logic [31:0] addr, input logic [31:0] exp,
                           input string name);
      drive(3'(1 << sid), 1'b0, 1'b0, addr, 32'h0);
      tick();
      check({name, "_setup"}, pget(sid), exp);
      bus0.penable = 1'b1;
      tick();
      check({name, "_access"}, pget(sid), exp);
      idle();
      tick();
      check({name, "_after"}, pget(sid), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{
         '{1'b0, 8'h04, RST0,           "rst_load"},
         '{1'b0, 8'h08, RST0,           "rst_count"},
         '{1'b0, 8'h00, 32'h0,          "rst_ctrl"},
         '{1'b0, 8'h0C, 32'h0,          "rst_status"},
         '{1'b0, 8'h10, 32'h0,          "rst_scr0"},
         '{1'b1, 8'h14, 32'h1234_5678,  ""},
         '{1'b0, 8'h14, 32'h1234_5678,  "rd_scr1"},
         '{1'b1, 8'h2C, 32'h0BAD_F00D,  ""},
         '{1'b0, 8'h2C, 32'h0BAD_F00D,  "rd_scr7"},
         '{1'b1, 8'h00, 32'hFFFF_FFF8,  ""},
         '{1'b0, 8'h00, 32'h0,          "ctrl_rsvd"},
         '{1'b1, 8'h08, 32'h0000_ABCD,  ""},
         '{1'b0, 8'h08, RST0,           "count_ro"},
         '{1'b1, 8'h30, 32'hFFFF_FFFF,  ""},
         '{1'b0, 8'h30, 32'h0,          "rd_hole"},
         '{1'b1, 8'h04, 32'h0000_0055,  ""},
         '{1'b0, 8'h04, 32'h0000_0055,  "rd_load"},
         '{1'b0, 8'h08, 32'h0000_0055,  "load_to_count"}
      };

      hresetn = 1'b0;
      idle();
      tick();
      tick();
      check("rst_prdata", bus0.prdata, 32'h0);
      check("rst_irq", {29'b0, irq}, 32'h0);
      check("rst_perr", {29'b0, perr}, 32'h0);
      hresetn = 1'b1;
      tick();

      // Register map
      for (int i = 0; i < NV; i++) begin
         if (tbl[i].wr) apb_write(0, {24'h0, tbl[i].addr}, tbl[i].data);
         else           apb_read(0, {24'h0, tbl[i].addr}, tbl[i].data, tbl[i].name);
      end
      apb_read(1, 32'h14, 32'h0, "slv1_scr1");
      apb_read(2, 32'h14, 32'h0, "slv2_scr1");
      check("map_perr", {31'b0, perr[0]}, 32'h0);

      // One-shot timer
      apb_write(0, 32'h04, 32'd3);
      apb_write(0, 32'h00, 32'h3);
      apb_read(0, 32'h08, 32'd3, "cnt_first");
      tick();
      check("irq_lag", {31'b0, irq[0]}, 32'h0);
      tick();
      check("irq_set", {31'b0, irq[0]}, 32'h1);
      apb_read(0, 32'h0C, 32'h1, "status_to");
      apb_read(0, 32'h00, 32'h2, "en_cleared");
      apb_read(0, 32'h08, 32'h0, "cnt_hold");
      apb_write(0, 32'h0C, 32'h1);
      check("irq_still", {31'b0, irq[0]}, 32'h1);
      tick();
      check("irq_clr", {31'b0, irq[0]}, 32'h0);

      // Autoreload, with a W1C landing on an expiry edge
      apb_write(0, 32'h04, 32'd2);
      apb_write(0, 32'h00, 32'h7);
      tick();
      apb_write(0, 32'h0C, 32'h1);
      apb_read(0, 32'h0C, 32'h1, "to_set_wins");
      check("irq_ar", {31'b0, irq[0]}, 32'h1);
      apb_read(0, 32'h08, 32'd2, "cnt_reload");
      tick();
      apb_read(0, 32'h08, 32'd1, "cnt_dec_ar");
      apb_write(0, 32'h00, 32'h0);
      apb_write(0, 32'h0C, 32'h1);
      tick();
      check("irq_off", {31'b0, irq[0]}, 32'h0);
      apb_read(0, 32'h0C, 32'h0, "status_clr");
      apb_read(0, 32'h08, 32'd2, "cnt_frozen");

      // Enable without setup
      drive(3'b001, 1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF);
      tick();
      idle();
      tick();
      check("perr_nosetup", {31'b0, perr[0]}, 32'h1);
      apb_read(0, 32'h14, 32'h1234_5678, "scr1_kept");
      apb_read(0, 32'h0C, 32'h2, "status_perr");
      apb_write(0, 32'h0C, 32'h2);
      check("perr_lag", {31'b0, perr[0]}, 32'h1);
      tick();
      check("perr_clr1", {31'b0, perr[0]}, 32'h0);

      // Address change between setup and access
      drive(3'b001, 1'b0, 1'b1, 32'h18, 32'h0000_BEEF);
      tick();
      drive(3'b001, 1'b1, 1'b1, 32'h1C, 32'h0000_BEEF);
      tick();
      idle();
      tick();
      check("perr_addr", {31'b0, perr[0]}, 32'h1);
      apb_read(0, 32'h18, 32'h0, "scr2_dropped");
      apb_read(0, 32'h1C, 32'h0, "scr3_dropped");
      apb_write(0, 32'h0C, 32'h2);
      tick();
      check("perr_clr2", {31'b0, perr[0]}, 32'h0);

      // Enable held for a second access cycle
      drive(3'b001, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
      tick();
      bus0.penable = 1'b1;
      tick();
      tick();
      idle();
      tick();
      check("perr_wait", {31'b0, perr[0]}, 32'h1);
      apb_read(0, 32'h20, 32'hCAFE_F00D, "scr4_commit");
      apb_write(0, 32'h0C, 32'h2);
      tick();
      check("perr_clr3", {31'b0, perr[0]}, 32'h0);

      // Back-to-back write then read with no idle cycle
      drive(3'b001, 1'b0, 1'b1, 32'h10, 32'hA5A5_5A5A);
      tick();
      bus0.penable = 1'b1;
      tick();
      drive(3'b001, 1'b0, 1'b0, 32'h10, 32'h0);
      tick();
      check("b2b_setup", bus0.prdata, 32'hA5A5_5A5A);
      bus0.penable = 1'b1;
      tick();
      check("b2b_access", bus0.prdata, 32'hA5A5_5A5A);
      idle();
      tick();
      check("b2b_after", bus0.prdata, 32'h0);
      tick();
      check("b2b_perr", {31'b0, perr[0]}, 32'h0);

      // Raise irq and perr, then reset in the access cycle of a write
      apb_write(0, 32'h04, 32'd1);
      apb_write(0, 32'h00, 32'h3);
      tick();
      tick();
      tick();
      drive(3'b001, 1'b1, 1'b1, 32'h14, 32'h0);
      tick();
      idle();
      tick();
      check("pre_rst_irq", {31'b0, irq[0]}, 32'h1);
      check("pre_rst_perr", {31'b0, perr[0]}, 32'h1);
      drive(3'b001, 1'b0, 1'b1, 32'h18, 32'h0000_0077);
      tick();
      bus0.penable = 1'b1;
      hresetn = 1'b0;
      tick();
      check("mid_rst_prdata", bus0.prdata, 32'h0);
      check("mid_rst_irq", {31'b0, irq[0]}, 32'h0);
      check("mid_rst_perr", {31'b0, perr[0]}, 32'h0);
      hresetn = 1'b1;
      idle();
      tick();
      apb_read(0, 32'h18, 32'h0, "scr2_aborted");
      apb_read(0, 32'h14, 32'h0, "scr1_reset");
      apb_read(0, 32'h04, RST0, "load_reset");
      apb_read(0, 32'h08, RST0, "count_reset");
      apb_read(0, 32'h0C, 32'h0, "status_reset");
      apb_read(0, 32'h30, 32'h0, "rd_30");
      apb_write(0, 32'h3C, 32'hFFFF_FFFF);
      apb_read(0, 32'h3C, 32'h0, "rd_3c");
      tick();
      check("hole_perr", {31'b0, perr[0]}, 32'h0);
      check("others_quiet", {29'b0, perr[2:1], 1'b0} | {29'b0, irq[2:1], 1'b0}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
